wall_map_server: RTL and testbench
==================================

Name: wall_map_server

Overview:
- Responder side of the tanks' wall-collision query: each tank drives check_x/check_y and samples hit_wall; this block answers from a tile map.
- Serves both tank query ports plus one handshaked bullet port by time-multiplexing a single-port synchronous-read map RAM.
- With the optional feature, destructible bricks are cleared on bullet impact.
- Sits in the game core between the two tank instances, the bullet manager and the renderer's map loader.

Parameters:
- TILE_SHIFT, 2, tile size is 2^TILE_SHIFT pixels (4x4); tile index = coord >> TILE_SHIFT
- ADDR_W, 12, map address width; addr = {ty[5:0], tx[5:0]}
- AREA_X_MIN, 4, leftmost playable pixel
- AREA_X_MAX, 195, rightmost playable pixel
- AREA_Y_MIN, 4, top playable pixel
- AREA_Y_MAX, 139, bottom playable pixel

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- t0_x  in  8  tank 0 check_x
- t0_y  in  8  tank 0 check_y
- t0_hit  out  1  tank 0 hit_wall
- t1_x  in  8  tank 1 check_x
- t1_y  in  8  tank 1 check_y
- t1_hit  out  1  tank 1 hit_wall
- blt_req  in  1  bullet query request (level)
- blt_x  in  8  bullet probe x
- blt_y  in  8  bullet probe y
- blt_ack  out  1  one-cycle response strobe
- blt_hit  out  1  probe is wall; valid with blt_ack
- blt_broke  out  1  brick destroyed; valid with blt_ack
- load_en  in  1  map-load mode
- load_addr  in  ADDR_W  load address
- load_data  in  2  cell value to write

Behaviour:
- Cell codes: 0 EMPTY, 1 SOLID, 2 BRICK, 3 reserved (treated as SOLID). A cell is a wall if its code is non-zero.
- Out-of-area coords (x<AREA_X_MIN, x>AREA_X_MAX, y<AREA_Y_MIN, y>AREA_Y_MAX) give hit=1 and broke=0. A read is still issued, but its data is ignored and no write occurs.
- RAM: single port, 1-cycle read latency, at most one access per cycle. Contents are unaffected by rst.
- FSM states: LOAD, ISSUE_T0, ISSUE_T1, ISSUE_B, RESP_B.
  - ISSUE_T0: sample t0_x/y, issue read. Next state: ISSUE_T1.
  - ISSUE_T1: sample t1_x/y, issue read. Next state: ISSUE_B if blt_req=1, else ISSUE_T0.
  - ISSUE_B: latch blt_x/y, issue read. Next state: RESP_B.
  - RESP_B: blt_ack=1 for exactly one cycle; blt_hit = wall(cell) or out-of-area. Next state: ISSUE_T0.
    - Brick handling is defined under Optional Feature; no read is issued in RESP_B.
  - Any state with load_en=1: go to LOAD.
  - LOAD: write load_data to load_addr each cycle; t0_hit=t1_hit=1 forced. On load_en=0, go to ISSUE_T0.
- Tank outputs are registered and updated the cycle after read data returns, so they change 2 cycles after their ISSUE state.
- Worst-case latency from a stable coordinate change to a correct tN_hit is 6 cycles. The game_tick period makes this invisible to tanks.
- Bullet handshake:
  - The requester holds blt_req/blt_x/blt_y until blt_ack.
  - blt_req is sampled only in ISSUE_T1. A new request seen in the cycle of blt_ack is served next round, never twice within one round.
  - Dropping blt_req before ack: the request is still completed; the ack is ignored by the requester.
- Simultaneous events: load_en beats the bullet request, which beats tank polling. An in-flight bullet request aborted by load_en gets no ack; the requester reissues.
- Reset values: t0_hit=1, t1_hit=1 (block motion until the first read), blt_ack=0, blt_hit=0, blt_broke=0, state ISSUE_T0.
- rst asserted during RESP_B suppresses the brick write.

Optional Feature:
- Macro: WALL_DESTRUCT_EN.
- Defined: in RESP_B, a BRICK cell within the area is overwritten with EMPTY in the same cycle, and blt_broke=1 with blt_ack.
- Undefined: BRICK behaves like SOLID, blt_broke is tied to 0, and the block never writes the RAM outside LOAD.

Decomposition:
- Shared package tank_game_pkg holds:
  - CELL_EMPTY/SOLID/BRICK/RSVD (2-bit) codes
  - TILE_SHIFT
  - AREA_* bounds, shared with the tank and bullet blocks
  - FSM state enum
- One sub-module, wall_map_ram: single-port RAM, 2^ADDR_W x 2, synchronous read, write-first ignored (never read and write the same cycle).

Test Plan:
- Load cell (ty=5, tx=5) = SOLID, all else EMPTY. Set t0=(20,20) -> t0_hit=1 within 6 cycles. Set t0=(24,20) -> t0_hit=0 within 6 cycles.
- Set t1=(196,70) and t1=(3,70) -> t1_hit=1 without any map wall. Set t1=(195,139) on an EMPTY cell -> t1_hit=0.
- Bullet req at (20,20) over SOLID -> single blt_ack pulse, blt_hit=1, blt_broke=0. Re-read the cell -> still SOLID.
- With WALL_DESTRUCT_EN, BRICK at tile (10,10), bullet req at (41,42):
  - First response: blt_ack with blt_hit=1, blt_broke=1.
  - Second request: blt_hit=0.
  - Tank probe at (40,40) then reports hit=0.
  - Without the macro: blt_hit=1 and blt_broke=0 on both requests.
- Assert load_en during ISSUE_B -> no blt_ack, both tank hits forced to 1. Release -> the held request is acked in the next round.
- Assert rst in the RESP_B cycle over a BRICK -> brick remains, all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/tank_game_pkg.sv
// Shared tank-game constants: map cell codes, tile geometry,
// playable-area bounds and the wall map server FSM states.
package tank_game_pkg;

    localparam int TILE_SHIFT = 2;
    localparam int MAP_ADDR_W = 12;

    localparam logic [7:0] AREA_X_MIN = 8'd4;
    localparam logic [7:0] AREA_X_MAX = 8'd195;
    localparam logic [7:0] AREA_Y_MIN = 8'd4;
    localparam logic [7:0] AREA_Y_MAX = 8'd139;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_SOLID = 2'd1;
    localparam logic [1:0] CELL_BRICK = 2'd2;
    localparam logic [1:0] CELL_RSVD  = 2'd3;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_ISSUE_T0,
        ST_ISSUE_T1,
        ST_ISSUE_B,
        ST_RESP_B
    } map_state_t;

    function automatic logic out_of_area(
        input logic [7:0] x,
        input logic [7:0] y
    );
        return (x < AREA_X_MIN) || (x > AREA_X_MAX) ||
               (y < AREA_Y_MIN) || (y > AREA_Y_MAX);
    endfunction

    function automatic logic [MAP_ADDR_W-1:0] tile_addr(
        input logic [7:0] x,
        input logic [7:0] y
    );
        return {y[TILE_SHIFT +: 6], x[TILE_SHIFT +: 6]};
    endfunction

endpackage

// File: rtl/wall_map_server_if.sv
// Bullet probe channel: level request with coordinates, one-cycle
// acknowledge strobe carrying the hit/broke result.
interface wall_map_server_if;

    logic       req;
    logic [7:0] x;
    logic [7:0] y;
    logic       ack;
    logic       hit;
    logic       broke;

    modport master (
        output req, x, y,
        input  ack, hit, broke
    );

    modport slave (
        input  req, x, y,
        output ack, hit, broke
    );

endinterface

// File: rtl/wall_map_ram.sv
// Single-port tile map RAM, 2 bits per cell, one-cycle read latency.
module wall_map_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        wdata,
    output logic [1:0]        rdata
);

    logic [1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        else if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/wall_map_server.sv
// Time-multiplexed wall query server for two tanks and the bullet port.
// Define WALL_DESTRUCT_EN to let bullets clear BRICK cells.
module wall_map_server
    import tank_game_pkg::*;
#(
    parameter int ADDR_W = MAP_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        t0_x,
    input  logic [7:0]        t0_y,
    output logic              t0_hit,
    input  logic [7:0]        t1_x,
    input  logic [7:0]        t1_y,
    output logic              t1_hit,
    input  logic              blt_req,
    input  logic [7:0]        blt_x,
    input  logic [7:0]        blt_y,
    output logic              blt_ack,
    output logic              blt_hit,
    output logic              blt_broke,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [1:0]        load_data
);

    map_state_t state, next;

    logic [7:0]        qx, qy;
    logic [ADDR_W-1:0] q_addr, b_addr, addr;
    logic              q_oob, b_oob, pend_oob;
    logic              pend_t0, pend_t1;
    logic              we, re;
    logic [1:0]        wdata, rdata;
`ifdef WALL_DESTRUCT_EN
    logic              brk;
`endif

    always_comb begin
        qx = t0_x;
        qy = t0_y;
        unique case (state)
            ST_ISSUE_T1: begin qx = t1_x;  qy = t1_y;  end
            ST_ISSUE_B:  begin qx = blt_x; qy = blt_y; end
            default:     ;
        endcase
    end

    assign q_addr = tile_addr(qx, qy);
    assign q_oob  = out_of_area(qx, qy);

    always_comb begin
        next    = state;
        addr    = q_addr;
        we      = 1'b0;
        re      = 1'b0;
        wdata   = load_data;
        blt_ack = 1'b0;
`ifdef WALL_DESTRUCT_EN
        brk     = 1'b0;
`endif
        unique case (state)
            ST_LOAD: begin
                addr = load_addr;
                we   = load_en;
                next = ST_ISSUE_T0;
            end
            ST_ISSUE_T0: begin
                re   = 1'b1;
                next = ST_ISSUE_T1;
            end
            ST_ISSUE_T1: begin
                re   = 1'b1;
                next = blt_req ? ST_ISSUE_B : ST_ISSUE_T0;
            end
            ST_ISSUE_B: begin
                re   = 1'b1;
                next = ST_RESP_B;
            end
            ST_RESP_B: begin
                blt_ack = 1'b1;
                addr    = b_addr;
                wdata   = CELL_EMPTY;
                next    = ST_ISSUE_T0;
`ifdef WALL_DESTRUCT_EN
                brk = !b_oob && (rdata == CELL_BRICK);
                we  = brk;
`endif
            end
            default: next = ST_ISSUE_T0;
        endcase
        // Map loading pre-empts everything, including a pending response.
        if (load_en) begin
            next = ST_LOAD;
            if (state != ST_LOAD) begin
                we      = 1'b0;
                blt_ack = 1'b0;
            end
        end
        if (rst)
            we = 1'b0;
    end

    assign blt_hit = blt_ack && (b_oob || (rdata != CELL_EMPTY));
`ifdef WALL_DESTRUCT_EN
    assign blt_broke = blt_ack && brk;
`else
    assign blt_broke = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_ISSUE_T0;
            t0_hit   <= 1'b1;
            t1_hit   <= 1'b1;
            pend_t0  <= 1'b0;
            pend_t1  <= 1'b0;
            pend_oob <= 1'b0;
            b_oob    <= 1'b0;
            b_addr   <= '0;
        end else begin
            state    <= next;
            pend_t0  <= (state == ST_ISSUE_T0);
            pend_t1  <= (state == ST_ISSUE_T1);
            pend_oob <= q_oob;
            if (state == ST_ISSUE_B) begin
                b_oob  <= q_oob;
                b_addr <= q_addr;
            end
            if (load_en || state == ST_LOAD) begin
                t0_hit <= 1'b1;
                t1_hit <= 1'b1;
            end else begin
                if (pend_t0)
                    t0_hit <= pend_oob || (rdata != CELL_EMPTY);
                if (pend_t1)
                    t1_hit <= pend_oob || (rdata != CELL_EMPTY);
            end
        end
    end

    wall_map_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (we),
        .re    (re),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_wall_map_server.sv
// Self-checking bench for wall_map_server against a tile-map model.
// Build with WALL_DESTRUCT_EN to check brick destruction.
module tb_wall_map_server;

`ifdef WALL_DESTRUCT_EN
    localparam bit DESTRUCT = 1'b1;
`else
    localparam bit DESTRUCT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  t0_x = 8'd0, t0_y = 8'd0;
    logic [7:0]  t1_x = 8'd0, t1_y = 8'd0;
    logic        t0_hit, t1_hit;
    logic        load_en = 1'b0;
    logic [11:0] load_addr = '0;
    logic [1:0]  load_data = '0;

    wall_map_server_if bus ();

    wall_map_server dut (
        .clk       (clk),
        .rst       (rst),
        .t0_x      (t0_x),
        .t0_y      (t0_y),
        .t0_hit    (t0_hit),
        .t1_x      (t1_x),
        .t1_y      (t1_y),
        .t1_hit    (t1_hit),
        .blt_req   (bus.req),
        .blt_x     (bus.x),
        .blt_y     (bus.y),
        .blt_ack   (bus.ack),
        .blt_hit   (bus.hit),
        .blt_broke (bus.broke),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [1:0] map_m [4096];

    typedef struct {
        bit       tank;
        int       x;
        int       y;
        bit       exp;
    } tvec_t;

    tvec_t vecs [14];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic bit m_oob(input int x, input int y);
        return x < 4 || x > 195 || y < 4 || y > 139;
    endfunction

    function automatic int m_idx(input int x, input int y);
        return (y / 4) * 64 + (x / 4);
    endfunction

    function automatic bit m_wall(input int x, input int y);
        return m_oob(x, y) || map_m[m_idx(x, y)] != 2'd0;
    endfunction

    task automatic bullet_model(input int x, input int y,
                                output bit eh, output bit eb);
        eh = m_wall(x, y);
        eb = DESTRUCT && !m_oob(x, y) && map_m[m_idx(x, y)] == 2'd2;
        if (eb)
            map_m[m_idx(x, y)] = 2'd0;
    endtask

    task automatic load_begin();
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_write(input int a, input logic [1:0] d);
        load_addr = a[11:0];
        load_data = d;
        @(negedge clk);
    endtask

    task automatic load_end();
        load_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_tank(input bit t, input int x, input int y);
        if (t) begin t1_x = x[7:0]; t1_y = y[7:0]; end
        else begin t0_x = x[7:0]; t0_y = y[7:0]; end
    endtask

    task automatic bullet(input int x, input int y,
                          output bit h, output bit b, output int n);
        @(negedge clk);
        bus.x = x[7:0];
        bus.y = y[7:0];
        bus.req = 1'b1;
        n = 0; h = 1'b0; b = 1'b0;
        for (int i = 0; i < 40 && n == 0; i++) begin
            @(negedge clk);
            if (bus.ack) begin
                n = 1; h = bus.hit; b = bus.broke;
                bus.req = 1'b0;
            end
        end
        bus.req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.ack) n++;
        end
    endtask

    task automatic bullet_check(input int x, input int y);
        bit h, b, eh, eb;
        int n;
        bullet(x, y, h, b, n);
        bullet_model(x, y, eh, eb);
        chk($sformatf("blt_acks(%0d,%0d)", x, y), n, 1);
        chk($sformatf("blt_hit(%0d,%0d)", x, y), h, eh);
        chk($sformatf("blt_broke(%0d,%0d)", x, y), b, eb);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h, b;
        int n;
        bus.req = 1'b0;
        bus.x = 8'd0;
        bus.y = 8'd0;
        vecs[0]  = '{0, 20, 20, 1};
        vecs[1]  = '{0, 24, 20, 0};
        vecs[2]  = '{1, 196, 70, 1};
        vecs[3]  = '{1, 3, 70, 1};
        vecs[4]  = '{1, 195, 139, 0};
        vecs[5]  = '{0, 100, 3, 1};
        vecs[6]  = '{0, 100, 140, 1};
        vecs[7]  = '{1, 4, 4, 0};
        vecs[8]  = '{0, 81, 121, 1};
        vecs[9]  = '{1, 40, 40, 1};
        vecs[10] = '{0, 23, 23, 1};
        vecs[11] = '{1, 19, 20, 0};
        vecs[12] = '{1, 195, 140, 1};
        vecs[13] = '{0, 196, 139, 1};

        for (int a = 0; a < 4096; a++)
            map_m[a] = ($urandom_range(7) == 0) ?
                       2'($urandom_range(3)) : 2'd0;
        map_m[5*64 + 5]   = 2'd1;
        map_m[5*64 + 6]   = 2'd0;
        map_m[5*64 + 4]   = 2'd0;
        map_m[34*64 + 48] = 2'd0;
        map_m[1*64 + 1]   = 2'd0;
        map_m[10*64 + 10] = 2'd2;
        map_m[12*64 + 12] = 2'd2;
        map_m[30*64 + 20] = 2'd3;

        repeat (3) @(negedge clk);
        chk("reset_t0_hit", t0_hit, 1);
        chk("reset_t1_hit", t1_hit, 1);
        chk("reset_blt_ack", bus.ack, 0);
        chk("reset_blt_hit", bus.hit, 0);
        chk("reset_blt_broke", bus.broke, 0);
        rst = 1'b0;

        load_begin();
        for (int a = 0; a < 4096; a++)
            load_write(a, map_m[a]);
        load_end();

        foreach (vecs[i]) begin
            set_tank(vecs[i].tank, vecs[i].x, vecs[i].y);
            repeat (8) @(negedge clk);
            chk($sformatf("tank%0d_vec%0d", vecs[i].tank, i),
                vecs[i].tank ? t1_hit : t0_hit, vecs[i].exp);
        end

        bullet_check(20, 20);
        set_tank(0, 20, 20);
        repeat (8) @(negedge clk);
        chk("solid_still_t0", t0_hit, 1);
        bullet_check(20, 20);
        bullet_check(41, 42);
        bullet_check(41, 42);
        set_tank(0, 40, 40);
        repeat (8) @(negedge clk);
        chk("brick_after_t0", t0_hit, DESTRUCT ? 0 : 1);
        bullet_check(0, 0);
        bullet_check(196, 100);

        // load_en raised while the bullet read is in ISSUE_B
        @(negedge clk);
        rst = 1'b1;
        bus.req = 1'b1; bus.x = 8'd20; bus.y = 8'd20;
        set_tank(0, 24, 20);
        set_tank(1, 195, 139);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("issue_b_no_ack", bus.ack, 0);
        chk("issue_b_t0_hit", t0_hit, 0);
        load_en = 1'b1;
        load_addr = 12'(1*64 + 1);
        load_data = map_m[1*64 + 1];
        @(negedge clk);
        chk("load_t0_forced", t0_hit, 1);
        chk("load_t1_forced", t1_hit, 1);
        chk("load_no_ack0", bus.ack, 0);
        repeat (2) begin
            @(negedge clk);
            chk("load_no_ack", bus.ack, 0);
        end
        load_en = 1'b0;
        n = 0; h = 1'b0;
        for (int i = 0; i < 20 && n == 0; i++) begin
            @(negedge clk);
            if (bus.ack) begin
                n = 1; h = bus.hit;
                bus.req = 1'b0;
            end
        end
        bus.req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.ack) n++;
        end
        chk("reissue_acks", n, 1);
        chk("reissue_hit", h, 1);
        repeat (8) @(negedge clk);
        chk("after_load_t0", t0_hit, 0);
        chk("after_load_t1", t1_hit, 0);

        // reset during RESP_B over a brick
        @(negedge clk);
        rst = 1'b1;
        bus.req = 1'b1; bus.x = 8'd49; bus.y = 8'd49;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("resp_b_ack", bus.ack, 1);
        rst = 1'b1;
        bus.req = 1'b0;
        @(negedge clk);
        chk("rst_resp_t0_hit", t0_hit, 1);
        chk("rst_resp_t1_hit", t1_hit, 1);
        chk("rst_resp_ack", bus.ack, 0);
        chk("rst_resp_hit", bus.hit, 0);
        chk("rst_resp_broke", bus.broke, 0);
        rst = 1'b0;
        bullet_check(49, 49);

        for (int i = 0; i < 30; i++) begin
            int x0, y0, x1, y1;
            x0 = $urandom_range(255); y0 = $urandom_range(160);
            x1 = $urandom_range(255); y1 = $urandom_range(160);
            set_tank(0, x0, y0);
            set_tank(1, x1, y1);
            repeat (8) @(negedge clk);
            chk($sformatf("rnd_t0(%0d,%0d)", x0, y0),
                t0_hit, m_wall(x0, y0));
            chk($sformatf("rnd_t1(%0d,%0d)", x1, y1),
                t1_hit, m_wall(x1, y1));
        end

        for (int i = 0; i < 20; i++)
            bullet_check($urandom_range(200), $urandom_range(145));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
